pe_ws_dbuf: RTL
===============

# pe_ws_dbuf

Parametrised weight-stationary processing element for the Lego systolic array. It is the next generation of the single-weight MAC PE. New behaviour:
- double-buffered weight (shadow + active) so the next tile's weights load while the current tile computes
- signed/unsigned arithmetic
- optional saturation with a sticky overflow flag
- a local-accumulate mode with explicit drain
- fully registered valid propagation

One instance per array cell. Activations move right, partial sums move down.

## Interface

Parameters:
- DATA_W, 8: activation/weight width
- DATA_W_OUT, 32: partial-sum width, must be ≥ 2*DATA_W+1
- SIGNED, 1: 1 = two's-complement operands and psum, 0 = unsigned
- SATURATE, 1: 1 = clamp on overflow, 0 = wrap modulo 2^DATA_W_OUT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  in_act/in_psum valid this cycle
- in_act  in  DATA_W  activation from left
- in_psum  in  DATA_W_OUT  partial sum from top
- w_load  in  1  write w_data into shadow weight
- w_data  in  DATA_W  weight value
- w_swap  in  1  promote shadow weight to active
- acc_mode  in  1  0 = pass-through psum, 1 = local accumulate; static while any valid is in flight
- acc_clear  in  1  zero accumulator and overflow flag
- drain  in  1  emit accumulator (acc_mode=1 only)
- out_act  out  DATA_W  registered activation to right
- act_valid_out  out  1  out_act valid
- out_psum  out  DATA_W_OUT  registered psum down
- valid_out  out  1  out_psum valid
- shadow_full  out  1  shadow holds an unpromoted weight
- overflow  out  1  sticky saturation/wrap event

## Operation

**Product**
- prod = in_act × w_active, full 2*DATA_W width.
- Sign- or zero-extension to DATA_W_OUT follows SIGNED.

**Weight buffer**
- w_load writes the shadow register and sets shadow_full. A load is accepted regardless of valid_in.
- w_swap with shadow_full=1 copies shadow to active and clears shadow_full. w_swap with shadow_full=0 is ignored; the active weight is unchanged.
- w_load and w_swap in the same cycle: the old shadow content is promoted, w_data enters the shadow, and shadow_full stays 1.
- A swap takes effect for the MAC on the next cycle. A MAC in the swap cycle uses the old weight.

**Pass-through mode (acc_mode=0)**
- On valid_in: out_psum ← sat(in_psum + prod) and valid_out ← 1.
- drain and the accumulator are ignored.

**Accumulate mode (acc_mode=1)**
- in_psum is ignored.
- On valid_in: acc ← sat(acc + prod).
- drain: out_psum ← sat(acc + (valid_in ? prod : 0)), valid_out ← 1, and acc ← 0.
- acc_clear and drain in the same cycle: drain output is produced, acc ← 0, overflow ← 0.
- acc_clear alone: acc ← 0, overflow ← 0, no output.

**Activation forwarding (both modes)**
- On valid_in: out_act ← in_act and act_valid_out ← 1.
- Otherwise act_valid_out ← 0 and out_act holds its value.

**Saturation**
- Applies when the true sum exceeds the DATA_W_OUT range.
- SIGNED=1: clamp to 2^(DATA_W_OUT-1)-1 or -2^(DATA_W_OUT-1). SIGNED=0: clamp to 2^DATA_W_OUT-1.
- SATURATE=0 wraps instead.
- overflow sets in either case and is cleared only by acc_clear or reset.

## Timing

**Reset values** (all state and outputs 0):
- w_active, shadow, shadow_full
- acc, overflow
- out_act, out_psum, valid_out, act_valid_out

**Latency**
- Exactly 1 cycle from valid_in/drain to valid_out and act_valid_out.
- No stalls, so the PE accepts one operand per cycle.

**Output holding and in-flight data**
- valid_out is a single-cycle pulse per accepted operation. out_psum holds its last value when valid_out=0.
- Reset mid-operation discards in-flight data, both weights, and the accumulator, with no partial output.

## Structure

- Package pe_pkg holds:
  - the pe_mode_e enum (PE_PASS, PE_ACC)
  - the saturation-limit functions sat_max/sat_min(width, signed)
  - the shared DATA_W / DATA_W_OUT defaults for all array cells
- Sub-module pe_sat_add: combinational widened adder (DATA_W_OUT+1 bits) with clamp/wrap and an overflow output. It is reused for both the pass-through and accumulate paths.
- Top-level contents: weight buffer, accumulator, output registers.

## Test plan

1. **Double-buffer swap.** Load 3, swap, then load 5 while streaming act=2 with psum=0. Required out_psum = 6,6,…; swap, then 10 on the cycle after the swap+1.
2. **Simultaneous load and swap.** Shadow=4, w_load=7 with w_swap in the same cycle. Required: active=4, shadow=7, shadow_full=1.
3. **Signed arithmetic.** SIGNED=1, act=-128, w=-128, psum=-1. Required out_psum=16383. With SIGNED=0, act=0x80, w=0x80: out_psum=16384-1 wraps to 16383 only if psum=0xFFFFFFFF; check that the value wraps modulo 2^32 when SATURATE=0.
4. **Accumulate and drain.** acc_mode=1, w=2, acts 1,2,3 on consecutive cycles, drain on the 3rd. Required: a single valid_out with out_psum=12, and acc=0 afterwards.
5. **Saturation.** SIGNED=1, DATA_W_OUT=17, psum=65535, prod=127. Required: out_psum=65535, overflow=1 held until acc_clear.
6. **Async reset mid-stream.** Assert rst_n=0 between clock edges. Required: all outputs 0 immediately, and no valid_out on the first cycle after release.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary PE family: array-wide width
// defaults, the PE operating-mode enum and saturation-limit helpers.
package pe_pkg;

  // Defaults used by every cell of the systolic array.
  localparam int PE_DATA_W     = 8;
  localparam int PE_DATA_W_OUT = 32;

  // Width of the value returned by the limit helpers; callers cast down.
  localparam int PE_LIMIT_W = 64;

  typedef enum logic {
    PE_PASS = 1'b0,
    PE_ACC  = 1'b1
  } pe_mode_e;

  // Largest representable value of a width-bit number, as a bit pattern.
  function automatic logic [PE_LIMIT_W-1:0] sat_max(input int width, input bit is_signed);
    if (is_signed) begin
      return (64'd1 << (width - 1)) - 64'd1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

  // Smallest representable value of a width-bit number, as a bit pattern
  // in the low width bits (only the sign bit set for two's complement).
  function automatic logic [PE_LIMIT_W-1:0] sat_min(input int width, input bit is_signed);
    if (is_signed) begin
      return 64'd1 << (width - 1);
    end
    return 64'd0;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational adder with one guard bit. Flags results that fall outside
// the W-bit range and either clamps them to the nearest limit or lets them
// wrap modulo 2^W.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int W        = PE_DATA_W_OUT,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam logic [W-1:0] MAX_V = W'(sat_max(W, SIGNED));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W, SIGNED));

  logic [W:0] w_a_ext;
  logic [W:0] w_b_ext;
  logic [W:0] w_sum_wide;

  // The extra bit holds the true sign (signed) or carry (unsigned).
  assign w_a_ext    = {SIGNED & i_a[W-1], i_a};
  assign w_b_ext    = {SIGNED & i_b[W-1], i_b};
  assign w_sum_wide = w_a_ext + w_b_ext;

  // Signed: guard bit disagreeing with the W-bit sign means out of range.
  assign o_ovf = SIGNED ? (w_sum_wide[W] ^ w_sum_wide[W-1]) : w_sum_wide[W];

  // Clamp toward the side the true result lies on, or pass the wrapped bits.
  always_comb begin
    o_sum = w_sum_wide[W-1:0];
    if (SATURATE && o_ovf) begin
      if (SIGNED && w_sum_wide[W]) begin
        o_sum = MIN_V;
      end else begin
        o_sum = MAX_V;
      end
    end
  end

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a shadow/active weight pair, optional
// local accumulation with explicit drain, and a sticky overflow flag.
// Activations move right, partial sums move down, both one cycle per hop.
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W     = PE_DATA_W,
  parameter int DATA_W_OUT = PE_DATA_W_OUT,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     in_act,
  input  logic [DATA_W_OUT-1:0] in_psum,
  input  logic                  w_load,
  input  logic [DATA_W-1:0]     w_data,
  input  logic                  w_swap,
  input  logic                  acc_mode,
  input  logic                  acc_clear,
  input  logic                  drain,
  output logic [DATA_W-1:0]     out_act,
  output logic                  act_valid_out,
  output logic [DATA_W_OUT-1:0] out_psum,
  output logic                  valid_out,
  output logic                  shadow_full,
  output logic                  overflow
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0]     r_w_active;
  logic [DATA_W-1:0]     r_w_shadow;
  logic                  r_shadow_full;
  logic [DATA_W_OUT-1:0] r_acc;
  logic                  r_overflow;
  logic [DATA_W-1:0]     r_out_act;
  logic                  r_act_valid;
  logic [DATA_W_OUT-1:0] r_out_psum;
  logic                  r_valid_out;

  pe_mode_e              w_mode;
  logic                  w_is_acc;
  logic [PROD_W-1:0]     w_act_ext;
  logic [PROD_W-1:0]     w_wt_ext;
  logic [PROD_W-1:0]     w_prod;
  logic [DATA_W_OUT-1:0] w_prod_ext;
  logic [DATA_W_OUT-1:0] w_add_a;
  logic [DATA_W_OUT-1:0] w_add_b;
  logic [DATA_W_OUT-1:0] w_sum;
  logic                  w_sum_ovf;
  logic                  w_swap_ok;
  logic                  w_emit;
  logic                  w_add_used;

  assign w_mode   = acc_mode ? PE_ACC : PE_PASS;
  assign w_is_acc = (w_mode == PE_ACC);

  // Operands are extended to the product width first, so the low PROD_W
  // bits of a plain multiply are exact for both signed and unsigned data.
  assign w_act_ext  = {{DATA_W{SIGNED & in_act[DATA_W-1]}}, in_act};
  assign w_wt_ext   = {{DATA_W{SIGNED & r_w_active[DATA_W-1]}}, r_w_active};
  assign w_prod     = w_act_ext * w_wt_ext;
  assign w_prod_ext = {{(DATA_W_OUT-PROD_W){SIGNED & w_prod[PROD_W-1]}}, w_prod};

  // One adder serves both modes: the base is the accumulator or the
  // incoming psum, and the product only joins when an operand is valid
  // (a drain without valid_in emits the accumulator as is).
  assign w_add_a = w_is_acc ? r_acc : in_psum;
  assign w_add_b = valid_in ? w_prod_ext : '0;

  pe_sat_add #(
    .W        (DATA_W_OUT),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_sum),
    .o_ovf (w_sum_ovf)
  );

  assign w_swap_ok  = w_swap & r_shadow_full;
  assign w_emit     = w_is_acc ? drain : valid_in;
  // The adder result only matters (and may only raise overflow) when it
  // lands somewhere: an output, or the accumulator.
  assign w_add_used = valid_in | (w_is_acc & drain);

  // Weight double buffer: a swap promotes the pre-edge shadow, so a
  // simultaneous load refills the shadow and keeps it marked full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_active    <= '0;
      r_w_shadow    <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      if (w_swap_ok) begin
        r_w_active <= r_w_shadow;
      end
      if (w_load) begin
        r_w_shadow    <= w_data;
        r_shadow_full <= 1'b1;
      end else if (w_swap_ok) begin
        r_shadow_full <= 1'b0;
      end
    end
  end

  // Local accumulator: cleared by acc_clear or by being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clear || (w_is_acc && drain)) begin
      r_acc <= '0;
    end else if (w_is_acc && valid_in) begin
      r_acc <= w_sum;
    end
  end

  // Sticky overflow: set by any used out-of-range sum, cleared by acc_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (acc_clear) begin
      r_overflow <= 1'b0;
    end else if (w_add_used && w_sum_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  // Psum output register: value holds between single-cycle valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_psum  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_emit;
      if (w_emit) begin
        r_out_psum <= w_sum;
      end
    end
  end

  // Activation forwarding to the right-hand neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_act   <= '0;
      r_act_valid <= 1'b0;
    end else begin
      r_act_valid <= valid_in;
      if (valid_in) begin
        r_out_act <= in_act;
      end
    end
  end

  assign out_act       = r_out_act;
  assign act_valid_out = r_act_valid;
  assign out_psum      = r_out_psum;
  assign valid_out     = r_valid_out;
  assign shadow_full   = r_shadow_full;
  assign overflow      = r_overflow;

endmodule
